// File: rtl/seed_pkg.sv
// Shared widths and collector state encoding for the SEED byte collector.
package seed_pkg;
   localparam int SEED_BYTE_W  = 8;
   localparam int SEED_WORD_W  = 32;
   localparam int SEED_BLOCK_W = 128;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      TAIL,
      HOLD
   } collect_state_t;
endpackage

// File: rtl/seed_word_assembler.sv
// Captures the store's F byte one cycle after each drain strobe and rebuilds the word in load order.
// The first captured byte lands in [7:0]; word_done pulses the cycle after the last capture.
module seed_word_assembler
   import seed_pkg::*;
#(
   parameter int BYTES_PER_WORD = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   strobe,
   input  logic [SEED_BYTE_W-1:0] f_in,
   output logic                   word_last,
   output logic [SEED_WORD_W-1:0] word,
   output logic                   word_done
);
   localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam logic [CW-1:0] BYTE_LAST = CW'(BYTES_PER_WORD - 1);

   logic                   cap_pend;
   logic [CW-1:0]          byte_cnt_cap;
   logic [SEED_WORD_W-1:0] word_reg;

   assign word_last = cap_pend && (byte_cnt_cap == BYTE_LAST);

   // Merged view including the byte being captured this cycle, so the top can slot a finished word
   // on the same edge as the last capture.
   always_comb begin
      word = word_reg;
      if (cap_pend) begin
         word[byte_cnt_cap*SEED_BYTE_W +: SEED_BYTE_W] = f_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_pend     <= 1'b0;
         byte_cnt_cap <= '0;
         word_reg     <= '0;
         word_done    <= 1'b0;
      end else begin
         cap_pend  <= strobe;
         word_done <= word_last;
         if (cap_pend) begin
            word_reg     <= word;
            byte_cnt_cap <= word_last ? '0 : byte_cnt_cap + 1'b1;
         end
      end
   end
endmodule

// File: rtl/seed_byte_collector.sv
// Drains BYTES_PER_WORD bytes from the byte store per start and packs WORDS_PER_BLOCK words into a block.
// Define SEED_COLLECT_OVR_EN to add a sticky overrun flag for starts that arrive while busy.
module seed_byte_collector
   import seed_pkg::*;
#(
   parameter int BYTES_PER_WORD  = 4,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   start,
   input  logic                                   load_busy,
   input  logic [SEED_BYTE_W-1:0]                 f_in,
   output logic                                   enable_output,
   output logic                                   busy,
   output logic                                   word_done,
   output logic [SEED_WORD_W*WORDS_PER_BLOCK-1:0] block_out,
   output logic                                   block_valid,
   input  logic                                   block_ready
`ifdef SEED_COLLECT_OVR_EN
   ,
   output logic                                   overrun
`endif
);
   localparam int SW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
   localparam int WW = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
   localparam logic [SW-1:0] STROBE_LAST = SW'(BYTES_PER_WORD - 1);
   localparam logic [WW-1:0] WORD_LAST   = WW'(WORDS_PER_BLOCK - 1);

   collect_state_t         state;
   collect_state_t         state_nxt;
   logic [SW-1:0]          strobe_cnt;
   logic [WW-1:0]          word_cnt;
   logic                   word_last;
   logic [SEED_WORD_W-1:0] word;
   logic                   handshake;

   seed_word_assembler #(
      .BYTES_PER_WORD(BYTES_PER_WORD)
   ) u_assembler (
      .clk      (clk),
      .reset_n  (reset_n),
      .strobe   (enable_output),
      .f_in     (f_in),
      .word_last(word_last),
      .word     (word),
      .word_done(word_done)
   );

   assign busy        = (state != IDLE);
   assign block_valid = (state == HOLD);
   assign handshake   = block_valid & block_ready;

   // load_busy only stalls the strobe; the drain simply lasts longer, so the store never sees extra pulses.
   always_comb begin
      state_nxt     = state;
      enable_output = 1'b0;
      unique case (state)
         IDLE:  if (start) state_nxt = DRAIN;
         DRAIN: begin
            enable_output = ~load_busy;
            if (enable_output && (strobe_cnt == STROBE_LAST)) state_nxt = TAIL;
         end
         TAIL:  if (word_last) state_nxt = (word_cnt == WORD_LAST) ? HOLD : IDLE;
         HOLD:  if (block_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         strobe_cnt <= '0;
         word_cnt   <= '0;
         block_out  <= '0;
      end else begin
         state <= state_nxt;
         if (enable_output) begin
            strobe_cnt <= (strobe_cnt == STROBE_LAST) ? '0 : strobe_cnt + 1'b1;
         end
         if (word_last) begin
            block_out[word_cnt*SEED_WORD_W +: SEED_WORD_W] <= word;
            if (word_cnt != WORD_LAST) word_cnt <= word_cnt + 1'b1;
         end
         if (handshake) word_cnt <= '0;
      end
   end

`ifdef SEED_COLLECT_OVR_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (start && busy) begin
         overrun <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_seed_byte_collector.sv
// Randomized scoreboard bench for seed_byte_collector with a behavioural byte store and block model.
module tb_seed_byte_collector;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         load_busy = 1'b0;
   logic         block_ready = 1'b0;
   logic [7:0]   f_in = 8'h00;
   logic         enable_output, busy, word_done, block_valid;
   logic [127:0] block_out;
`ifdef SEED_COLLECT_OVR_EN
   logic         overrun;
`endif

   always #5 clk = ~clk;

   seed_byte_collector dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .load_busy    (load_busy),
      .f_in         (f_in),
      .enable_output(enable_output),
      .busy         (busy),
      .word_done    (word_done),
      .block_out    (block_out),
      .block_valid  (block_valid),
      .block_ready  (block_ready)
`ifdef SEED_COLLECT_OVR_EN
      ,
      .overrun      (overrun)
`endif
   );

   int           n_cmp = 0;
   int           n_err = 0;
   logic [7:0]   store_q[$];
   logic [31:0]  exp_words[$];
   logic [127:0] exp_blocks[$];
   logic [127:0] m_acc = '0;
   int           m_words = 0;
   int           mon_slot = 0;
   int           hs_cnt = 0;
   logic         prev_valid = 1'b0;
   logic [127:0] held = '0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm, input int act, input int exp);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Byte store: first loaded byte leaves first, F registered one cycle after the strobe, zeros shift in.
   always @(posedge clk) begin
      if (enable_output) f_in <= (store_q.size() > 0) ? store_q.pop_front() : 8'h00;
   end

   // Monitor: compares every word_done and every block handshake against the scoreboard queues.
   always @(negedge clk) begin
      if (reset_n) begin
         if (word_done) begin
            if (exp_words.size() == 0) fail_now("unexpected_word_done", 1, 0);
            else chk($sformatf("word_slot%0d", mon_slot), 128'(block_out[mon_slot*32 +: 32]), 128'(exp_words.pop_front()));
            mon_slot = (mon_slot + 1) % 4;
         end
         if (block_valid && prev_valid) chk("block_stable", block_out, held);
         if (block_valid && block_ready) begin
            hs_cnt++;
            if (exp_blocks.size() == 0) fail_now("unexpected_block", 1, 0);
            else chk("block", block_out, exp_blocks.pop_front());
         end
         prev_valid = block_valid && !block_ready;
         held       = block_out;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // A strobe is issued in each drain cycle without load_busy until four have gone out; done two cycles later.
   function automatic void exp_timing(input logic [31:0] mask, output logic [31:0] en, output int done);
      int k;
      k = 0;
      en = '0;
      done = -1;
      for (int c = 1; c < 32 && k < 4; c++) begin
         if (!mask[c]) begin
            en[c] = 1'b1;
            k++;
            if (k == 4) done = c + 2;
         end
      end
   endfunction

   // Entered just after a rising edge (cycle 0); returns just after the edge following word_done.
   task automatic issue_word(input logic [31:0] w, input logic [31:0] mask,
                             output logic [31:0] en_mask, output int done_c);
      for (int i = 0; i < 4; i++) store_q.push_back(w[8*i +: 8]);
      exp_words.push_back(w);
      m_acc[m_words*32 +: 32] = w;
      m_words++;
      if (m_words == 4) begin
         exp_blocks.push_back(m_acc);
         m_words = 0;
      end
      en_mask = '0;
      done_c  = -1;
      start   = 1'b1;
      for (int c = 1; c < 32 && done_c < 0; c++) begin
         step();
         start     = 1'b0;
         load_busy = mask[c];
         @(negedge clk);
         if (enable_output) en_mask[c] = 1'b1;
         if (word_done) done_c = c;
      end
      load_busy = 1'b0;
      if (done_c < 0) fail_now("word_done_timeout", done_c, 0);
      step();
   endtask

   task automatic do_word(input logic [31:0] w, input logic [31:0] mask,
                          output logic [31:0] en_mask, output int done_c);
      logic [31:0] e_en;
      int          e_done;
      exp_timing(mask, e_en, e_done);
      issue_word(w, mask, en_mask, done_c);
      chk("strobe_pattern", 128'(en_mask), 128'(e_en));
      chk("done_cycle", 128'(done_c), 128'(e_done));
      @(negedge clk);
      chk("busy_valid_after_word", 128'({busy, block_valid}), (m_words == 0) ? 128'd3 : 128'd0);
      step();
   endtask

   // Holds block_ready low for 'delay' cycles (optionally pulsing start at cycle start_at), then hands off.
   task automatic release_block(input int delay, input int start_at, input bit start_on_ready);
      int h0;
      h0 = hs_cnt;
      for (int i = 0; i < delay; i++) begin
         start = (i == start_at);
         @(negedge clk);
         if (i == start_at) chk("hold_on_start", 128'({busy, block_valid}), 128'd3);
         step();
      end
      block_ready = 1'b1;
      start       = start_on_ready;
      step();
      block_ready = 1'b0;
      start       = 1'b0;
      @(negedge clk);
      chk("idle_after_handshake", 128'({busy, block_valid}), 128'd0);
      if (hs_cnt != h0 + 1) fail_now("handshake_count", hs_cnt - h0, 1);
      repeat (8) step();
      @(negedge clk);
      chk("idle_after_ignored_start", 128'({busy, enable_output}), 128'd0);
      step();
   endtask

   task automatic check_outputs_zero(input string nm);
      chk({nm, "_ctl"}, 128'({enable_output, busy, word_done, block_valid}), 128'd0);
      chk({nm, "_block"}, block_out, 128'd0);
   endtask

   logic [31:0] en;
   int          dc;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("after_reset");
`ifdef SEED_COLLECT_OVR_EN
      chk("overrun_reset", 128'(overrun), 128'd0);
`endif
      step();

      // Block A: AA,BB,CC,DD latency word followed by three random words.
      do_word(32'hDDCCBBAA, 32'h0, en, dc);
      chk("first_strobes", 128'(en), 128'h1E);
      chk("first_done", 128'(dc), 128'd6);
      chk("first_word", 128'(block_out[31:0]), 128'hDDCCBBAA);
      for (int i = 0; i < 3; i++) do_word($urandom, 32'h0, en, dc);
      release_block(2, -1, 1'b0);

      // Block B: known words, load_busy stalls the second drain in cycles 2-3.
      do_word(32'h11111111, 32'h0, en, dc);
      do_word(32'h22222222, 32'h0000000C, en, dc);
      chk("stall_strobes", 128'(en), 128'h72);
      chk("stall_done", 128'(dc), 128'd8);
      do_word(32'h33333333, 32'h0, en, dc);
      do_word(32'h44444444, 32'h0, en, dc);
      chk("block_b", block_out, 128'h44444444_33333333_22222222_11111111);
`ifdef SEED_COLLECT_OVR_EN
      chk("overrun_before_hold_start", 128'(overrun), 128'd0);
`endif
      release_block(10, 3, 1'b0);
`ifdef SEED_COLLECT_OVR_EN
      chk("overrun_after_hold_start", 128'(overrun), 128'd1);
`endif

      // Block C: start coincides with the handshake.
      for (int i = 0; i < 4; i++) do_word($urandom, 32'h0, en, dc);
      release_block(1, -1, 1'b1);

      // Mid-operation reset in TAIL with two words already slotted.
      do_word($urandom, 32'h0, en, dc);
      do_word($urandom, 32'h0, en, dc);
      for (int i = 0; i < 4; i++) store_q.push_back(8'($urandom));
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      reset_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      exp_words.delete();
      exp_blocks.delete();
      m_acc      = '0;
      m_words    = 0;
      mon_slot   = 0;
      prev_valid = 1'b0;
      step();
      reset_n = 1'b1;
      step();
      do_word(32'hCAFEF00D, 32'h0, en, dc);
      chk("fresh_slot0", block_out, 128'h00000000_00000000_00000000_CAFEF00D);
      for (int i = 0; i < 3; i++) do_word($urandom, 32'h0, en, dc);
      release_block(0, -1, 1'b0);

      // Randomized blocks with random load_busy stalls and release timing.
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 4; i++) do_word($urandom, $urandom & $urandom & 32'h00001FFE, en, dc);
         release_block($urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      if (exp_words.size() != 0) fail_now("words_left", exp_words.size(), 0);
      if (exp_blocks.size() != 0) fail_now("blocks_left", exp_blocks.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
